// File: rtl/exe_result_select_if.sv
// ============================================================================
// Module      : exe_result_select_if
// Description : EX-side and writeback-side handshake bundle for the execute
//               result selector, including the mul/div return path and Hi/Lo view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exe_result_select_if #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
);
  logic               in_valid;
  logic               in_ready;
  logic [FUNCT_W-1:0] funct;
  logic [WIDTH-1:0]   alu_out;
  logic [WIDTH-1:0]   shift_out;
  logic               md_valid;
  logic [WIDTH-1:0]   md_hi;
  logic [WIDTH-1:0]   md_lo;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               md_pending;
  logic               md_err;

  modport master (
    output in_valid, funct, alu_out, shift_out, md_valid, md_hi, md_lo, out_ready,
    input  in_ready, out_valid, data_out, hi_q, lo_q, md_pending, md_err
  );

  modport slave (
    input  in_valid, funct, alu_out, shift_out, md_valid, md_hi, md_lo, out_ready,
    output in_ready, out_valid, data_out, hi_q, lo_q, md_pending, md_err
  );
endinterface

`default_nettype wire

// File: rtl/exe_result_select.sv
// ============================================================================
// Module      : exe_result_select
// Description : Registered EX-stage writeback selector owning the Hi/Lo pair;
//               stalls Hi/Lo consumers while one MULTU/DIVU is outstanding.
//               Optional MTHI/MTLO support via EXE_RESULT_SELECT_MTHILO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_result_select #(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6
) (
  input  wire logic          clk,
  input  wire logic          rst,
  exe_result_select_if.slave bus
);

  localparam logic [FUNCT_W-1:0] C_F_AND   = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] C_F_OR    = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] C_F_ADD   = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] C_F_SUB   = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] C_F_SLT   = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] C_F_SLL   = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] C_F_SRL   = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] C_F_MULTU = FUNCT_W'(6'b011001);
  localparam logic [FUNCT_W-1:0] C_F_DIVU  = FUNCT_W'(6'b011011);
  localparam logic [FUNCT_W-1:0] C_F_MFHI  = FUNCT_W'(6'b010000);
  localparam logic [FUNCT_W-1:0] C_F_MFLO  = FUNCT_W'(6'b010010);
`ifdef EXE_RESULT_SELECT_MTHILO_EN
  localparam logic [FUNCT_W-1:0] C_F_MTHI  = FUNCT_W'(6'b010001);
  localparam logic [FUNCT_W-1:0] C_F_MTLO  = FUNCT_W'(6'b010011);
`endif

  logic             r_out_valid;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_md_pending;
  logic             r_md_err;

  logic             w_is_md;
  logic             w_is_mf;
  logic             w_is_mt;
  logic             w_stall;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sel;

  always_comb begin
    w_is_md = (bus.funct == C_F_MULTU) || (bus.funct == C_F_DIVU);
    w_is_mf = (bus.funct == C_F_MFHI)  || (bus.funct == C_F_MFLO);
`ifdef EXE_RESULT_SELECT_MTHILO_EN
    w_is_mt = (bus.funct == C_F_MTHI)  || (bus.funct == C_F_MTLO);
`else
    w_is_mt = 1'b0;
`endif
    // Anything touching Hi/Lo waits for the outstanding mul/div, including
    // the cycle its result arrives, so reads always see the fresh pair.
    w_stall    = r_md_pending && (w_is_md || w_is_mf || w_is_mt);
    w_in_ready = (!r_out_valid || bus.out_ready) && !w_stall;
    w_accept   = bus.in_valid && w_in_ready;
  end

  always_comb begin
    w_sel = '0;
    case (bus.funct)
      C_F_AND, C_F_OR, C_F_ADD, C_F_SUB, C_F_SLT: w_sel = bus.alu_out;
      C_F_SLL, C_F_SRL:                           w_sel = bus.shift_out;
      C_F_MFHI:                                   w_sel = r_hi;
      C_F_MFLO:                                   w_sel = r_lo;
      default:                                    w_sel = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_data       <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_md_pending <= 1'b0;
      r_md_err     <= 1'b0;
    end else begin
      r_md_err <= bus.md_valid && !r_md_pending;

      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_data      <= w_sel;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      // A stray md_valid (nothing pending) leaves Hi/Lo untouched.
      if (bus.md_valid && r_md_pending) begin
        r_hi         <= bus.md_hi;
        r_lo         <= bus.md_lo;
        r_md_pending <= 1'b0;
      end else begin
        if (w_accept && w_is_md) begin
          r_md_pending <= 1'b1;
        end
`ifdef EXE_RESULT_SELECT_MTHILO_EN
        if (w_accept && (bus.funct == C_F_MTHI)) begin
          r_hi <= bus.alu_out;
        end
        if (w_accept && (bus.funct == C_F_MTLO)) begin
          r_lo <= bus.alu_out;
        end
`endif
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.data_out   = r_data;
  assign bus.hi_q       = r_hi;
  assign bus.lo_q       = r_lo;
  assign bus.md_pending = r_md_pending;
  assign bus.md_err     = r_md_err;

endmodule

`default_nettype wire

// File: tb/tb_exe_result_select.sv
// ============================================================================
// Module      : tb_exe_result_select
// Description : Scoreboard bench for exe_result_select with a cycle-level
//               reference model; honours EXE_RESULT_SELECT_MTHILO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_result_select;

  localparam logic [5:0] C_AND = 6'b100100, C_OR = 6'b100101, C_ADD = 6'b100000;
  localparam logic [5:0] C_SUB = 6'b100010, C_SLT = 6'b101010, C_SLL = 6'b000000;
  localparam logic [5:0] C_SRL = 6'b000010, C_MULTU = 6'b011001, C_DIVU = 6'b011011;
  localparam logic [5:0] C_MFHI = 6'b010000, C_MFLO = 6'b010010;
  localparam logic [5:0] C_MTHI = 6'b010001, C_MTLO = 6'b010011;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exe_result_select_if #(.WIDTH(32), .FUNCT_W(6)) bus ();

  exe_result_select #(.WIDTH(32), .FUNCT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: what the block should hold after each clock edge.
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_pend = 1'b0, m_err = 1'b0, m_ov = 1'b0, m_was_rst = 1'b1;
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic bit hilo_user(input logic [5:0] f);
    bit r;
    r = (f == C_MULTU) || (f == C_DIVU) || (f == C_MFHI) || (f == C_MFLO);
`ifdef EXE_RESULT_SELECT_MTHILO_EN
    r = r || (f == C_MTHI) || (f == C_MTLO);
`endif
    return r;
  endfunction

  function automatic logic [31:0] result_of(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] s, input logic [31:0] h,
                                            input logic [31:0] l);
    if (f == C_AND || f == C_OR || f == C_ADD || f == C_SUB || f == C_SLT) return a;
    if (f == C_SLL || f == C_SRL) return s;
    if (f == C_MFHI) return h;
    if (f == C_MFLO) return l;
    return 32'h0;
  endfunction

  // Checks current state against the model, then advances the model using
  // the inputs that will be sampled at the coming rising edge.
  task automatic step_model();
    logic        exp_rdy, acc, stall;
    logic [31:0] nh, nl;
    stall   = m_pend && hilo_user(bus.funct);
    exp_rdy = (!m_ov || bus.out_ready) && !stall;
    chk("out_valid",  {31'b0, bus.out_valid},  {31'b0, m_ov});
    chk("md_pending", {31'b0, bus.md_pending}, {31'b0, m_pend});
    chk("md_err",     {31'b0, bus.md_err},     {31'b0, m_err});
    chk("hi_q", bus.hi_q, m_hi);
    chk("lo_q", bus.lo_q, m_lo);
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    if (m_was_rst) chk("data_out_reset", bus.data_out, 32'h0);
    m_was_rst = !rst;
    if (!rst) begin
      m_hi = '0; m_lo = '0; m_pend = 1'b0; m_err = 1'b0; m_ov = 1'b0;
      sb_q.delete();
    end else begin
      acc = bus.in_valid && exp_rdy;
      nh  = m_hi;
      nl  = m_lo;
      if (acc) sb_q.push_back(result_of(bus.funct, bus.alu_out, bus.shift_out, m_hi, m_lo));
      if (bus.md_valid && m_pend) begin
        nh = bus.md_hi; nl = bus.md_lo;
      end
`ifdef EXE_RESULT_SELECT_MTHILO_EN
      if (acc && bus.funct == C_MTHI) nh = bus.alu_out;
      if (acc && bus.funct == C_MTLO) nl = bus.alu_out;
`endif
      m_err  = bus.md_valid && !m_pend;
      m_pend = (m_pend && !bus.md_valid) || (acc && (bus.funct == C_MULTU || bus.funct == C_DIVU));
      m_hi   = nh;
      m_lo   = nl;
      m_ov   = acc ? 1'b1 : (bus.out_ready ? 1'b0 : m_ov);
    end
  endtask

  task automatic cyc(input logic r, input logic iv, input logic [5:0] f,
                     input logic [31:0] a, input logic [31:0] s, input logic mv,
                     input logic [31:0] mh, input logic [31:0] ml, input logic ordy);
    @(posedge clk);
    #1;
    rst = r; bus.in_valid = iv; bus.funct = f; bus.alu_out = a; bus.shift_out = s;
    bus.md_valid = mv; bus.md_hi = mh; bus.md_lo = ml; bus.out_ready = ordy;
    @(negedge clk);
    step_model();
  endtask

  // Monitor: retires one scoreboard entry per consumed beat, and checks
  // that a stalled beat does not change.
  logic        hold_prev = 1'b0;
  logic [31:0] data_prev = '0;
  always @(negedge clk) begin
    if (hold_prev) begin
      chk("hold_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("hold_data", bus.data_out, data_prev);
    end
    if (rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", bus.data_out, 32'hxxxx_xxxx);
      end else begin
        chk("data_out", bus.data_out, sb_q.pop_front());
      end
    end
    hold_prev = rst && bus.out_valid && !bus.out_ready;
    data_prev = bus.data_out;
  end

  logic [5:0] codes [14];

  initial begin
    logic [5:0] f;
    logic       r, ordy, mv;
    codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SLL, C_SRL, C_MULTU,
              C_DIVU, C_MFHI, C_MFLO, C_MTHI, C_MTLO, 6'b111111};
    bus.in_valid = 1'b0; bus.funct = '0; bus.alu_out = '0; bus.shift_out = '0;
    bus.md_valid = 1'b0; bus.md_hi = '0; bus.md_lo = '0; bus.out_ready = 1'b0;

    cyc(0, 0, C_ADD, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, C_ADD, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, C_ADD, 32'h5, 0, 0, 0, 0, 1);
    cyc(1, 1, C_SLL, 0, 32'h10, 0, 0, 0, 1);
    cyc(1, 1, C_MULTU, 0, 0, 0, 0, 0, 1);
    repeat (3) cyc(1, 1, C_MFHI, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, C_MFHI, 0, 0, 1, 32'h1, 32'hFFFF_FFFE, 1);
    cyc(1, 1, C_MFHI, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, C_MFLO, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(1, 1, C_OR, 32'h33, 0, 0, 0, 0, 0);
    cyc(1, 1, C_OR, 32'h33, 0, 0, 0, 0, 1);
    cyc(1, 0, C_ADD, 0, 0, 1, 32'h5, 32'h6, 1);
    cyc(1, 1, 6'b111111, 32'h99, 32'h77, 0, 0, 0, 1);
    cyc(1, 1, C_MFHI, 0, 0, 1, 32'hAA, 32'hBB, 1);
    cyc(1, 1, C_MTLO, 32'hABCD, 0, 0, 0, 0, 1);
    cyc(1, 1, C_MFLO, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, C_DIVU, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, C_ADD, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, C_ADD, 0, 0, 1, 32'h12, 32'h34, 1);
    cyc(1, 0, C_ADD, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4000; i++) begin
      r    = ($urandom_range(0, 149) != 0);
      ordy = r && ($urandom_range(0, 3) != 0);
      mv   = m_pend ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      f    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                         : codes[$urandom_range(0, 13)];
      cyc(r, r && ($urandom_range(0, 4) != 0), f, $urandom, $urandom, mv,
          $urandom, $urandom, ordy);
    end

    repeat (4) cyc(1, 0, C_ADD, 0, 0, 0, 0, 0, 1);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
